// File: rtl/cpa_chunk_sequencer_pkg.sv
// rtl/cpa_chunk_sequencer_pkg.sv - shared state type and default sizes for the chunked CPA
package cpa_chunk_sequencer_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_CHUNK = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Chunk counter width; a single-chunk build still needs one bit.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/cpa_chunk_sequencer_prefix_cpa_cin.sv
// rtl/cpa_chunk_sequencer_prefix_cpa_cin.sv - combinational Sklansky prefix adder with carry-in
module prefix_cpa_cin #(
  parameter int CHUNK = 6
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  localparam int LV = (CHUNK > 1) ? $clog2(CHUNK) : 0;

  logic [CHUNK-1:0] prop;
  logic [CHUNK-1:0] gc, pc, gn, pn, cv;

  assign prop = a ^ b;

  always_comb begin
    gn = '0;
    pn = '0;
    cv = '0;
    gc = a & b;
    pc = prop;
    // Fold the carry-in into bit 0 so the prefix tree yields carries directly.
    gc[0] = gc[0] | (pc[0] & cin);
    for (int l = 0; l < LV; l++) begin
      gn = gc;
      pn = pc;
      for (int i = 0; i < CHUNK; i++) begin
        if (((i >> l) & 1) == 1) begin
          gn[i] = gc[i] | (pc[i] & gc[((i >> l) << l) - 1]);
          pn[i] = pc[i] & pc[((i >> l) << l) - 1];
        end
      end
      gc = gn;
      pc = pn;
    end
    cv[0] = cin;
    for (int i = 1; i < CHUNK; i++) cv[i] = gc[i-1];
  end

  assign sum  = prop ^ cv;
  assign cout = gc[CHUNK-1];

endmodule

// File: rtl/cpa_chunk_sequencer.sv
// rtl/cpa_chunk_sequencer.sv - multi-cycle adder running one shared CHUNK-bit CPA LSB chunk first
module cpa_chunk_sequencer
  import cpa_chunk_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (NCHUNK < 1)) begin : g_bad_params
    $error("cpa_chunk_sequencer: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_r;
  logic             cout_r;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             accept;
  logic [WIDTH+CHUNK-1:0] sum_cat;
  logic [WIDTH-1:0] sum_next;

  prefix_cpa_cin #(.CHUNK(CHUNK)) u_cpa (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // New chunk enters at the MSB end; after NCHUNK shifts the sum is aligned.
  assign sum_cat  = {chunk_sum, sum_sh};
  assign sum_next = sum_cat[WIDTH+CHUNK-1:CHUNK];

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready && !abort);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_sum   = sum_r;
  assign out_cout  = cout_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh  <= in_a;
      b_sh  <= in_b;
      carry <= in_cin;
      count <= '0;
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            a_sh   <= a_sh >> CHUNK;
            b_sh   <= b_sh >> CHUNK;
            carry  <= chunk_cout;
            sum_sh <= sum_next;
            count  <= count + CW'(1);
            if (count == CW'(NCHUNK - 1)) begin
              sum_r  <= sum_next;
              cout_r <= chunk_cout;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (abort || out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpa_chunk_sequencer.sv
// tb/tb_cpa_chunk_sequencer.sv - directed self-checking bench for cpa_chunk_sequencer
module tb_cpa_chunk_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic        in_cin;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic        out_cout;
  logic        busy;

  int checks = 0;
  int failures = 0;

  cpa_chunk_sequencer #(.WIDTH(24), .CHUNK(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [23:0] a, input logic [23:0] b, input logic c);
    in_a = a;
    in_b = b;
    in_cin = c;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_a = 24'h5A5A5A;
    in_b = 24'hA5A5A5;
    in_cin = 1'b1;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_result(input string tag, input logic [23:0] s, input logic c);
    step();
    step();
    step();
    chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, {8'd0, out_sum}, {8'd0, s});
    chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, c});
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drained"}, {30'd0, out_valid, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_sum"}, {8'd0, out_sum}, 32'd0);
    chk({tag, "_out_cout"}, {31'd0, out_cout}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    issue("basic", 24'h123456, 24'h0FEDCB, 1'b0);
    wait_result("basic", 24'h222221, 1'b0);
    consume("basic");

    // Abort while idle must not block the accept in the same cycle.
    abort = 1'b1;
    issue("ripple", 24'hFFFFFF, 24'h000000, 1'b1);
    abort = 1'b0;
    wait_result("ripple", 24'h000000, 1'b1);
    consume("ripple");

    out_ready = 1'b1;
    issue("b2b1", 24'h000001, 24'h000001, 1'b0);
    in_a = 24'h800000;
    in_b = 24'h800000;
    in_cin = 1'b0;
    in_valid = 1'b1;
    wait_result("b2b1", 24'h000002, 1'b0);
    chk("b2b_ready_in_done", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b2_no_idle", {30'd0, busy, out_valid}, 32'd2);
    wait_result("b2b2", 24'h000000, 1'b1);
    step();
    out_ready = 1'b0;
    chk("b2b_drained", {30'd0, out_valid, busy}, 32'd0);

    issue("bp", 24'h7FFFFF, 24'h000001, 1'b0);
    wait_result("bp", 24'h800000, 1'b0);
    in_a = 24'hABCDEF;
    in_b = 24'h654321;
    in_cin = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_sum", {8'd0, out_sum}, 32'h00800000);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_next_started", {30'd0, busy, out_valid}, 32'd2);
    wait_result("bp_next", 24'h111111, 1'b1);

    abort = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 24'h000010;
    in_b = 24'h000020;
    in_cin = 1'b0;
    #1;
    chk("abort_done_ready", {31'd0, in_ready}, 32'd0);
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("abort_done_idle", {30'd0, busy, out_valid}, 32'd0);
    chk("abort_done_stale", {8'd0, out_sum}, 32'h00111111);

    issue("abort_run", 24'h333333, 24'h111111, 1'b0);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_run_idle", {30'd0, busy, out_valid}, 32'd0);
    step();
    step();
    step();
    chk("abort_run_no_valid", {31'd0, out_valid}, 32'd0);
    issue("after_abort", 24'h000005, 24'h000007, 1'b0);
    wait_result("after_abort", 24'h00000C, 1'b0);
    consume("after_abort");

    issue("rst_mid", 24'h00FFFF, 24'h000001, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    step();
    rst = 1'b0;
    step();
    issue("post_rst", 24'h00ABCD, 24'h001234, 1'b1);
    wait_result("post_rst", 24'h00BE02, 1'b0);
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
